// File: rtl/pic_init_controller_pkg.sv
// Shared types and bit positions for the 8259-style PIC init/command
// register sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } pic_state_e;

  // ICW1 fields (written with A0=0, D4=1)
  localparam int IC4      = 0;
  localparam int SNGL     = 1;
  localparam int ADI      = 2;
  localparam int LTIM     = 3;
  localparam int ICW1_SEL = 4;

  // ICW2 carries the vector base in T7..T3
  localparam int ICW2_VEC_LSB = 3;
  localparam int ICW2_VEC_MSB = 7;

  // ICW4 fields
  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  // OCW2 fields: R/SL/EOI command and L2..L0 level
  localparam int OCW2_LVL_LSB = 0;
  localparam int OCW2_LVL_MSB = 2;
  localparam int OCW2_CMD_LSB = 5;
  localparam int OCW2_CMD_MSB = 7;

  // OCW3 fields
  localparam int RIS      = 0;
  localparam int RR       = 1;
  localparam int P        = 2;
  localparam int OCW3_SEL = 3;
  localparam int SMM      = 5;
  localparam int ESMM     = 6;

endpackage

// File: rtl/pic_init_controller_if.sv
// CPU write port of the PIC: one-cycle strobe, address bit A0 and data byte.
interface pic_init_controller_if;
  logic       wr_strobe;
  logic       a0;
  logic [7:0] din;

  modport master (output wr_strobe, output a0, output din);
  modport slave  (input  wr_strobe, input  a0, input  din);
endinterface

// File: rtl/pic_ocw_decode.sv
// Combinational classifier for a CPU write. ICW1 is recognised anywhere;
// the OCW classes only carry meaning once initialisation is complete, and
// an A0=1 write is also how the ICW2..ICW4 bytes arrive.
module pic_ocw_decode
  import pic_pkg::*;
(
  input  logic       a0,
  input  logic       icw1_bit,
  input  logic       ocw3_bit,
  output logic       is_icw1,
  output logic       is_ocw1,
  output logic       is_ocw2,
  output logic       is_ocw3
);

  // D4 splits ICW1 from the OCWs on the A0=0 port; D3 then splits OCW2/OCW3.
  always_comb begin
    is_icw1 = ~a0 & icw1_bit;
    is_ocw1 = a0;
    is_ocw2 = ~a0 & ~icw1_bit & ~ocw3_bit;
    is_ocw3 = ~a0 & ~icw1_bit & ocw3_bit;
  end

endmodule

// File: rtl/pic_init_controller.sv
// Register-write sequencer for an 8259-style PIC: walks ICW1..ICW4, then
// decodes OCW1..OCW3 and holds the configuration used by the rest of the PIC.
module pic_init_controller
  import pic_pkg::*;
#(
  parameter int         NUM_IR    = 8,
  parameter logic [4:0] RESET_VEC = 5'b00000
) (
  input  logic                  clk,
  input  logic                  reset,
  pic_init_controller_if.slave  bus,
  output logic                  init_done,
  output logic                  ltim,
  output logic                  adi,
  output logic                  sngl,
  output logic                  ic4,
  output logic [4:0]            vector_base,
  output logic [7:0]            icw3,
  output logic                  aeoi,
  output logic                  ms,
  output logic                  buf_mode,
  output logic                  sfnm,
  output logic                  upm,
  output logic [NUM_IR-1:0]     imr,
  output logic                  ocw2_valid,
  output logic [2:0]            ocw2_cmd,
  output logic [2:0]            ocw2_level,
  output logic                  read_isr,
  output logic                  special_mask,
  output logic                  poll_req
);

  pic_state_e state_q, state_d;

  logic              init_done_q, init_done_d;
  logic              ltim_q, ltim_d, adi_q, adi_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic [4:0]        vector_base_q, vector_base_d;
  logic [7:0]        icw3_q, icw3_d;
  logic              aeoi_q, aeoi_d, ms_q, ms_d, buf_mode_q, buf_mode_d;
  logic              sfnm_q, sfnm_d, upm_q, upm_d;
  logic [NUM_IR-1:0] imr_q, imr_d;
  logic              ocw2_valid_q, ocw2_valid_d;
  logic [2:0]        ocw2_cmd_q, ocw2_cmd_d, ocw2_level_q, ocw2_level_d;
  logic              read_isr_q, read_isr_d, special_mask_q, special_mask_d;
  logic              poll_req_q, poll_req_d;

  logic is_icw1, is_ocw1, is_ocw2, is_ocw3;

  pic_ocw_decode u_decode (
    .a0       (bus.a0),
    .icw1_bit (bus.din[ICW1_SEL]),
    .ocw3_bit (bus.din[OCW3_SEL]),
    .is_icw1  (is_icw1),
    .is_ocw1  (is_ocw1),
    .is_ocw2  (is_ocw2),
    .is_ocw3  (is_ocw3)
  );

  // Next-state and register updates; ICW1 restarts the sequence from any state.
  always_comb begin
    state_d        = state_q;
    ltim_d         = ltim_q;
    adi_d          = adi_q;
    sngl_d         = sngl_q;
    ic4_d          = ic4_q;
    vector_base_d  = vector_base_q;
    icw3_d         = icw3_q;
    aeoi_d         = aeoi_q;
    ms_d           = ms_q;
    buf_mode_d     = buf_mode_q;
    sfnm_d         = sfnm_q;
    upm_d          = upm_q;
    imr_d          = imr_q;
    ocw2_valid_d   = 1'b0;
    ocw2_cmd_d     = ocw2_cmd_q;
    ocw2_level_d   = ocw2_level_q;
    read_isr_d     = read_isr_q;
    special_mask_d = special_mask_q;
    poll_req_d     = 1'b0;

    if (bus.wr_strobe && is_icw1) begin
      ltim_d         = bus.din[LTIM];
      adi_d          = bus.din[ADI];
      sngl_d         = bus.din[SNGL];
      ic4_d          = bus.din[IC4];
      vector_base_d  = RESET_VEC;
      icw3_d         = 8'h00;
      aeoi_d         = 1'b0;
      ms_d           = 1'b0;
      buf_mode_d     = 1'b0;
      sfnm_d         = 1'b0;
      upm_d          = 1'b0;
      imr_d          = '0;
      read_isr_d     = 1'b0;
      special_mask_d = 1'b0;
      state_d        = WAIT_ICW2;
    end else if (bus.wr_strobe) begin
      case (state_q)
        UNINIT: begin
        end
        WAIT_ICW2: begin
          if (is_ocw1) begin
            vector_base_d = bus.din[ICW2_VEC_MSB:ICW2_VEC_LSB];
            if (!sngl_q)     state_d = WAIT_ICW3;
            else if (ic4_q)  state_d = WAIT_ICW4;
            else             state_d = READY;
          end
        end
        WAIT_ICW3: begin
          if (is_ocw1) begin
            icw3_d  = bus.din;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
        end
        WAIT_ICW4: begin
          if (is_ocw1) begin
            upm_d      = bus.din[ICW4_UPM];
            aeoi_d     = bus.din[ICW4_AEOI];
            ms_d       = bus.din[ICW4_MS];
            buf_mode_d = bus.din[ICW4_BUF];
            sfnm_d     = bus.din[ICW4_SFNM];
            state_d    = READY;
          end
        end
        READY: begin
          if (is_ocw1) begin
            imr_d = bus.din[NUM_IR-1:0];
          end else if (is_ocw2) begin
            ocw2_valid_d = 1'b1;
            ocw2_cmd_d   = bus.din[OCW2_CMD_MSB:OCW2_CMD_LSB];
            ocw2_level_d = bus.din[OCW2_LVL_MSB:OCW2_LVL_LSB];
          end else if (is_ocw3) begin
            if (bus.din[RR])   read_isr_d     = bus.din[RIS];
            if (bus.din[ESMM]) special_mask_d = bus.din[SMM];
            poll_req_d = bus.din[P];
          end
        end
        default: state_d = UNINIT;
      endcase
    end

    init_done_d = (state_d == READY);
  end

  // State and configuration registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= UNINIT;
      init_done_q    <= 1'b0;
      ltim_q         <= 1'b0;
      adi_q          <= 1'b0;
      sngl_q         <= 1'b0;
      ic4_q          <= 1'b0;
      vector_base_q  <= RESET_VEC;
      icw3_q         <= 8'h00;
      aeoi_q         <= 1'b0;
      ms_q           <= 1'b0;
      buf_mode_q     <= 1'b0;
      sfnm_q         <= 1'b0;
      upm_q          <= 1'b0;
      imr_q          <= '0;
      ocw2_valid_q   <= 1'b0;
      ocw2_cmd_q     <= 3'b000;
      ocw2_level_q   <= 3'b000;
      read_isr_q     <= 1'b0;
      special_mask_q <= 1'b0;
      poll_req_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_done_q    <= init_done_d;
      ltim_q         <= ltim_d;
      adi_q          <= adi_d;
      sngl_q         <= sngl_d;
      ic4_q          <= ic4_d;
      vector_base_q  <= vector_base_d;
      icw3_q         <= icw3_d;
      aeoi_q         <= aeoi_d;
      ms_q           <= ms_d;
      buf_mode_q     <= buf_mode_d;
      sfnm_q         <= sfnm_d;
      upm_q          <= upm_d;
      imr_q          <= imr_d;
      ocw2_valid_q   <= ocw2_valid_d;
      ocw2_cmd_q     <= ocw2_cmd_d;
      ocw2_level_q   <= ocw2_level_d;
      read_isr_q     <= read_isr_d;
      special_mask_q <= special_mask_d;
      poll_req_q     <= poll_req_d;
    end
  end

  assign init_done    = init_done_q;
  assign ltim         = ltim_q;
  assign adi          = adi_q;
  assign sngl         = sngl_q;
  assign ic4          = ic4_q;
  assign vector_base  = vector_base_q;
  assign icw3         = icw3_q;
  assign aeoi         = aeoi_q;
  assign ms           = ms_q;
  assign buf_mode     = buf_mode_q;
  assign sfnm         = sfnm_q;
  assign upm          = upm_q;
  assign imr          = imr_q;
  assign ocw2_valid   = ocw2_valid_q;
  assign ocw2_cmd     = ocw2_cmd_q;
  assign ocw2_level   = ocw2_level_q;
  assign read_isr     = read_isr_q;
  assign special_mask = special_mask_q;
  assign poll_req     = poll_req_q;

endmodule

// File: tb/tb_pic_init_controller.sv
// Self-checking bench for pic_init_controller: directed scenarios followed by
// random writes, compared against a queue-based model of the ICW sequence.
module tb_pic_init_controller;

  localparam int         NUM_IR    = 8;
  localparam logic [4:0] RESET_VEC = 5'b00000;

  logic clk = 1'b0;
  logic reset;

  logic              init_done, ltim, adi, sngl, ic4;
  logic [4:0]        vector_base;
  logic [7:0]        icw3;
  logic              aeoi, ms, buf_mode, sfnm, upm;
  logic [NUM_IR-1:0] imr;
  logic              ocw2_valid;
  logic [2:0]        ocw2_cmd, ocw2_level;
  logic              read_isr, special_mask, poll_req;

  pic_init_controller_if bus_if ();

  pic_init_controller #(
    .NUM_IR    (NUM_IR),
    .RESET_VEC (RESET_VEC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .init_done    (init_done),
    .ltim         (ltim),
    .adi          (adi),
    .sngl         (sngl),
    .ic4          (ic4),
    .vector_base  (vector_base),
    .icw3         (icw3),
    .aeoi         (aeoi),
    .ms           (ms),
    .buf_mode     (buf_mode),
    .sfnm         (sfnm),
    .upm          (upm),
    .imr          (imr),
    .ocw2_valid   (ocw2_valid),
    .ocw2_cmd     (ocw2_cmd),
    .ocw2_level   (ocw2_level),
    .read_isr     (read_isr),
    .special_mask (special_mask),
    .poll_req     (poll_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending holds the ICW numbers still owed by software,
  // configured says an ICW1 has been seen since reset.
  int                pending[$];
  bit                m_configured;
  logic [3:0]        m_icw1;
  logic [4:0]        m_vb;
  logic [7:0]        m_icw3;
  logic [4:0]        m_icw4;
  logic [NUM_IR-1:0] m_imr;
  logic              m_ocw2_valid;
  logic [2:0]        m_cmd, m_lvl;
  logic              m_risr, m_smm, m_poll;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    pending.delete();
    m_configured = 1'b0;
    m_icw1 = '0; m_vb = RESET_VEC; m_icw3 = '0; m_icw4 = '0; m_imr = '0;
    m_ocw2_valid = 1'b0; m_cmd = '0; m_lvl = '0;
    m_risr = 1'b0; m_smm = 1'b0; m_poll = 1'b0;
  endtask

  task automatic modelWrite(input logic a0v, input logic [7:0] d);
    int w;
    m_ocw2_valid = 1'b0;
    m_poll       = 1'b0;
    if (!a0v && d[4]) begin
      m_icw1 = d[3:0];
      m_vb = RESET_VEC; m_icw3 = '0; m_icw4 = '0; m_imr = '0;
      m_risr = 1'b0; m_smm = 1'b0;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0])  pending.push_back(4);
      m_configured = 1'b1;
    end else if (!m_configured) begin
      // writes before ICW1 are dropped
    end else if (pending.size() != 0) begin
      if (a0v) begin
        w = pending.pop_front();
        case (w)
          2: m_vb = d[7:3];
          3: m_icw3 = d;
          default: m_icw4 = d[4:0];
        endcase
      end
    end else if (a0v) begin
      m_imr = d[NUM_IR-1:0];
    end else if (!d[3]) begin
      m_ocw2_valid = 1'b1;
      m_cmd = d[7:5];
      m_lvl = d[2:0];
    end else begin
      if (d[1]) m_risr = d[0];
      if (d[6]) m_smm = d[5];
      m_poll = d[2];
    end
  endtask

  task automatic checkAll(input string pfx);
    checkOutput({pfx, "_init_done"}, init_done, (m_configured && pending.size() == 0));
    checkOutput({pfx, "_icw1"}, {ltim, adi, sngl, ic4}, m_icw1);
    checkOutput({pfx, "_vector_base"}, vector_base, m_vb);
    checkOutput({pfx, "_icw3"}, icw3, m_icw3);
    checkOutput({pfx, "_icw4"}, {sfnm, buf_mode, ms, aeoi, upm}, m_icw4);
    checkOutput({pfx, "_imr"}, imr, m_imr);
    checkOutput({pfx, "_ocw2_valid"}, ocw2_valid, m_ocw2_valid);
    checkOutput({pfx, "_ocw2_cmd"}, ocw2_cmd, m_cmd);
    checkOutput({pfx, "_ocw2_level"}, ocw2_level, m_lvl);
    checkOutput({pfx, "_read_isr"}, read_isr, m_risr);
    checkOutput({pfx, "_special_mask"}, special_mask, m_smm);
    checkOutput({pfx, "_poll_req"}, poll_req, m_poll);
  endtask

  // One write: driven on the falling edge, sampled on the rising edge,
  // outputs checked just after that edge.
  task automatic applyStimulus(input string pfx, input logic a0v, input logic [7:0] d);
    @(negedge clk);
    bus_if.wr_strobe = 1'b1;
    bus_if.a0        = a0v;
    bus_if.din       = d;
    modelWrite(a0v, d);
    @(posedge clk);
    #1;
    bus_if.wr_strobe = 1'b0;
    checkAll(pfx);
  endtask

  task automatic idleCycle(input string pfx);
    @(negedge clk);
    bus_if.wr_strobe = 1'b0;
    m_ocw2_valid = 1'b0;
    m_poll       = 1'b0;
    @(posedge clk);
    #1;
    checkAll(pfx);
  endtask

  // Reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic applyReset(input string pfx);
    @(negedge clk);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll(pfx);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       a;
    int         r;

    reset = 1'b1;
    bus_if.wr_strobe = 1'b0;
    bus_if.a0 = 1'b0;
    bus_if.din = 8'h00;
    modelReset();
    #3;
    checkAll("reset");
    checkOutput("reset_vector_base", vector_base, RESET_VEC);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("pre_icw1", 1'b1, 8'hAA);

    applyStimulus("single_icw1", 1'b0, 8'h12);
    checkOutput("single_not_done", init_done, 1'b0);
    applyStimulus("single_icw2", 1'b1, 8'h40);
    checkOutput("single_sngl", sngl, 1'b1);
    checkOutput("single_ic4", ic4, 1'b0);
    checkOutput("single_vb", vector_base, 5'b01000);
    checkOutput("single_done", init_done, 1'b1);

    applyStimulus("casc_icw1", 1'b0, 8'h11);
    applyStimulus("casc_icw2", 1'b1, 8'h48);
    applyStimulus("casc_icw3", 1'b1, 8'h04);
    checkOutput("casc_not_done", init_done, 1'b0);
    applyStimulus("casc_icw4", 1'b1, 8'h03);
    checkOutput("casc_icw3_val", icw3, 8'h04);
    checkOutput("casc_upm", upm, 1'b1);
    checkOutput("casc_aeoi", aeoi, 1'b1);
    checkOutput("casc_done", init_done, 1'b1);

    applyStimulus("op_ocw1", 1'b1, 8'hA5);
    checkOutput("op_imr", imr, 8'hA5);
    applyStimulus("op_ocw2", 1'b0, 8'h20);
    checkOutput("op_ocw2_pulse", ocw2_valid, 1'b1);
    checkOutput("op_ocw2_cmd", ocw2_cmd, 3'b001);
    checkOutput("op_ocw2_lvl", ocw2_level, 3'b000);
    applyStimulus("op_ocw3", 1'b0, 8'h0B);
    checkOutput("op_ocw2_drop", ocw2_valid, 1'b0);
    checkOutput("op_read_isr", read_isr, 1'b1);

    applyStimulus("reinit_imr", 1'b1, 8'hFF);
    applyStimulus("reinit_smm", 1'b0, 8'h68);
    checkOutput("reinit_smm_set", special_mask, 1'b1);
    applyStimulus("reinit_icw1", 1'b0, 8'h13);
    checkOutput("reinit_imr_clr", imr, 8'h00);
    checkOutput("reinit_smm_clr", special_mask, 1'b0);
    checkOutput("reinit_not_done", init_done, 1'b0);

    applyStimulus("poll_wait_ignored", 1'b0, 8'h0C);
    checkOutput("poll_wait_none", poll_req, 1'b0);
    applyStimulus("poll_icw2", 1'b1, 8'h50);
    checkOutput("poll_vb", vector_base, 5'b01010);
    applyStimulus("poll_icw4", 1'b1, 8'h00);
    applyStimulus("poll_rr", 1'b0, 8'h0B);
    applyStimulus("poll_ready", 1'b0, 8'h0C);
    checkOutput("poll_pulse", poll_req, 1'b1);
    checkOutput("poll_risr_kept", read_isr, 1'b1);
    idleCycle("poll_after");
    checkOutput("poll_one_cycle", poll_req, 1'b0);

    applyStimulus("arst_icw1", 1'b0, 8'h19);
    applyStimulus("arst_icw2", 1'b1, 8'hF8);
    applyReset("arst");
    checkOutput("arst_vb_now", vector_base, 5'b00000);
    checkOutput("arst_ltim_now", ltim, 1'b0);
    applyStimulus("arst_ignored", 1'b1, 8'h55);
    checkOutput("arst_icw3_kept", icw3, 8'h00);
    checkOutput("arst_uninit", init_done, 1'b0);

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      if (r < 2) begin
        applyReset("rnd_reset");
      end else if (r < 10) begin
        idleCycle("rnd_idle");
      end else if (r < 22) begin
        applyStimulus("rnd_icw1", 1'b0, d | 8'h10);
      end else begin
        a = 1'($urandom);
        if (!a) d = d & 8'hEF;
        applyStimulus("rnd_write", a, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_init_controller.md
Name: pic_init_controller

Overview:
- Register-write sequencer for the 8259-style PIC.
- Accepts CPU writes of data, A0 and a single-cycle write strobe.
- Steps through ICW1 → ICW2 → [ICW3] → [ICW4], then decodes OCW1/OCW2/OCW3 writes in operational mode.
- Holds the resulting configuration registers that drive the priority resolver, IMR and cascade logic.

Parameters:
- NUM_IR, 8, number of interrupt request lines; sets IMR width.
- RESET_VEC, 5'b00000, value of vector_base after reset/ICW1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_strobe  input  1  one-cycle write pulse, synchronous to clk.
- a0  input  1  address bit A0 of the write.
- din  input  8  write data D7..D0.
- init_done  output  1  high in READY state.
- ltim  output  1  ICW1 D3: 1 = level trigger.
- adi  output  1  ICW1 D2, stored only.
- sngl  output  1  ICW1 D1: 1 = single mode.
- ic4  output  1  ICW1 D0: ICW4 expected.
- vector_base  output  5  ICW2 D7..D3 (T7..T3).
- icw3  output  8  cascade slave map (master) or slave ID (slave).
- aeoi  output  1  ICW4 D1.
- ms  output  1  ICW4 D2.
- buf_mode  output  1  ICW4 D3.
- sfnm  output  1  ICW4 D4.
- upm  output  1  ICW4 D0.
- imr  output  NUM_IR  interrupt mask register (OCW1).
- ocw2_valid  output  1  one-cycle pulse on an OCW2 write.
- ocw2_cmd  output  3  R, SL, EOI (D7..D5); valid with ocw2_valid.
- ocw2_level  output  3  L2..L0; valid with ocw2_valid.
- read_isr  output  1  OCW3 read select: 0 = IRR, 1 = ISR.
- special_mask  output  1  OCW3 special mask mode.
- poll_req  output  1  one-cycle pulse when OCW3 P=1.

Behaviour:
- Reset values: state UNINIT, every output 0, vector_base = RESET_VEC.
- Reset is asynchronous, so it acts mid-sequence and mid-pulse.
- All outputs are registered and update on the clk edge that samples wr_strobe=1, so they are visible one cycle after the strobe.
- ICW1 detect: wr_strobe & ~a0 & din[4].
  - Takes priority in every state, including mid-sequence and READY.
  - Latches ltim/adi/sngl/ic4 from din[3:0].
  - Clears imr, special_mask, read_isr, aeoi, ms, buf_mode, sfnm and upm.
  - Clears icw3; sets vector_base = RESET_VEC.
  - Next state WAIT_ICW2.
- States and transitions:
  - UNINIT: only ICW1 is accepted; all other writes are ignored.
  - WAIT_ICW2: write with a0=1 latches vector_base = din[7:3]. Next state is WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
  - WAIT_ICW3: write with a0=1 latches icw3 = din. Next state is WAIT_ICW4 if ic4=1, else READY.
  - WAIT_ICW4: write with a0=1 latches upm=din[0], aeoi=din[1], ms=din[2], buf_mode=din[3], sfnm=din[4]. Next state READY.
  - In any WAIT state, an a0=0 write that is not ICW1 is ignored and the state holds.
  - READY, a0=1: OCW1, imr <= din[NUM_IR-1:0].
  - READY, a0=0, din[4:3]=00: OCW2. ocw2_valid=1 for one cycle, ocw2_cmd=din[7:5], ocw2_level=din[2:0]. No other state change.
  - READY, a0=0, din[4:3]=01: OCW3.
    - If din[1] (RR): read_isr <= din[0].
    - If din[6] (ESMM): special_mask <= din[5].
    - poll_req <= din[2], pulsed for one cycle.
    - Bits not enabled leave their registers unchanged.
- init_done = (state == READY). It drops in the cycle after a new ICW1.
- ocw2_cmd and ocw2_level hold their last value. Consumers sample them only when ocw2_valid=1.
- Back-to-back strobes on consecutive cycles are each processed; there is no stall and no busy output.
- wr_strobe held high for N cycles counts as N writes. Software must pulse it.

Decomposition:
- Package pic_pkg holds:
  - state enum {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY};
  - bit-position constants for ICW1 (IC4, SNGL, ADI, LTIM, ICW1_SEL=4), ICW4 fields, OCW2 fields and OCW3 fields (RIS, RR, P, SMM, ESMM, OCW3_SEL=3).
- One natural sub-module: pic_ocw_decode. It is combinational and classifies (a0, din) into is_icw1 / is_ocw1 / is_ocw2 / is_ocw3.
- The FSM and registers stay in pic_init_controller.

Test Plan:
- Single, no ICW4: ICW1 a0=0 din=0x12, then a0=1 din=0x40. Required: sngl=1, ic4=0, vector_base=5'b01000, init_done=1 one cycle after the second strobe; state skipped ICW3 and ICW4.
- Cascade with ICW4: din=0x11, 0x48, 0x04, 0x03. Required: icw3=0x04, upm=1, aeoi=1, init_done=1 only after the 4th write.
- Operational: a0=1 din=0xA5, then a0=0 din=0x20, then a0=0 din=0x0B. Required: imr=0xA5; ocw2_valid pulses one cycle with cmd=3'b001, level=0; read_isr=1.
- Re-init from READY with imr=0xFF and special_mask=1: new ICW1 0x13. Required: imr=0, special_mask=0, init_done=0 the next cycle, state WAIT_ICW2.
- Async reset asserted between ICW2 and ICW3 writes. Required: all outputs 0 immediately, without a clk edge; a following a0=1 write is ignored (UNINIT).
- Poll/ignore: in WAIT_ICW2, a0=0 din=0x0C is ignored. In READY, the same write pulses poll_req for exactly one cycle and leaves read_isr unchanged.
